// File: rtl/contador_pkg.sv
// Shared definitions for the occupancy counter: FSM state encoding and BCD digit width.
package contador_pkg;

    typedef enum logic [1:0] {
        VACIO   = 2'b00,
        PARCIAL = 2'b01,
        LLENO   = 2'b10
    } estado_t;

    localparam int BCD_W = 4;

endpackage

// File: rtl/contador_ocupacion_detector_flanco.sv
// Rising-edge detector; an armed flag suppresses a false event from a level already high at reset release.
module detector_flanco (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic ev_o
);

    logic prev_q;
    logic armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= d_i;
            armed_q <= 1'b1;
        end
    end

    assign ev_o = d_i & ~prev_q & armed_q;

endmodule

// File: rtl/contador_ocupacion.sv
// Saturating occupancy counter with full/empty status, full-alarm timer and reject/underflow pulses.
// Optional BCD digit outputs are enabled by defining CONTADOR_OCUPACION_BCD_EN.
module contador_ocupacion
    import contador_pkg::*;
#(
    parameter int CAPACITY  = 15,
    parameter int CNT_W     = 4,
    parameter int ALARM_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ent,
    input  logic             sal,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             reject,
    output logic             underflow,
`ifdef CONTADOR_OCUPACION_BCD_EN
    output logic [BCD_W-1:0] bcd_tens,
    output logic [BCD_W-1:0] bcd_units,
`endif
    output logic             alarm
);

    localparam int TMR_W = $clog2(ALARM_CYC + 1);
    localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] ALARM_T = TMR_W'(ALARM_CYC);

    estado_t          state_q;
    logic [CNT_W-1:0] count_q;
    logic [TMR_W-1:0] timer_q;
    logic             reject_q;
    logic             underflow_q;

    logic             ent_ev;
    logic             sal_ev;
    logic             inc;
    logic             dec;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_dec;

    detector_flanco u_det_ent (.clk(clk), .rst(rst), .d_i(ent), .ev_o(ent_ev));
    detector_flanco u_det_sal (.clk(clk), .rst(rst), .d_i(sal), .ev_o(sal_ev));

    // Simultaneous entry and exit cancel; bounds come from the state, so no wrap is possible.
    assign inc     = ent_ev & ~sal_ev & (state_q != LLENO);
    assign dec     = sal_ev & ~ent_ev & (state_q != VACIO);
    assign cnt_inc = count_q + 1'b1;
    assign cnt_dec = count_q - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= VACIO;
            count_q     <= '0;
            timer_q     <= '0;
            reject_q    <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            reject_q    <= ent_ev & ~sal_ev & (state_q == LLENO);
            underflow_q <= sal_ev & ~ent_ev & (state_q == VACIO);
            if (inc) begin
                count_q <= cnt_inc;
            end else if (dec) begin
                count_q <= cnt_dec;
            end
            case (state_q)
                VACIO: begin
                    if (inc) state_q <= (cnt_inc == CAP_C) ? LLENO : PARCIAL;
                end
                PARCIAL: begin
                    if (inc && cnt_inc == CAP_C) state_q <= LLENO;
                    else if (dec && cnt_dec == '0) state_q <= VACIO;
                end
                LLENO: begin
                    if (dec) state_q <= (cnt_dec == '0) ? VACIO : PARCIAL;
                end
                default: state_q <= VACIO;
            endcase
            // Timer runs only while staying in LLENO; a reject leaves it untouched.
            if (state_q == LLENO && !dec) begin
                if (timer_q != ALARM_T) timer_q <= timer_q + 1'b1;
            end else begin
                timer_q <= '0;
            end
        end
    end

    assign count     = count_q;
    assign full      = (state_q == LLENO);
    assign empty     = (state_q == VACIO);
    assign reject    = reject_q;
    assign underflow = underflow_q;
    assign alarm     = (timer_q == ALARM_T);

`ifdef CONTADOR_OCUPACION_BCD_EN
    logic [BCD_W-1:0] tens_q;
    logic [BCD_W-1:0] units_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_q  <= '0;
            units_q <= '0;
        end else if (inc) begin
            if (units_q == BCD_W'(9)) begin
                units_q <= '0;
                tens_q  <= tens_q + 1'b1;
            end else begin
                units_q <= units_q + 1'b1;
            end
        end else if (dec) begin
            if (units_q == '0) begin
                units_q <= BCD_W'(9);
                tens_q  <= tens_q - 1'b1;
            end else begin
                units_q <= units_q - 1'b1;
            end
        end
    end

    assign bcd_tens  = tens_q;
    assign bcd_units = units_q;
`endif

endmodule

// File: tb/tb_contador_ocupacion.sv
// Directed bench for contador_ocupacion (CAPACITY=15, ALARM_CYC=8); BCD checks when CONTADOR_OCUPACION_BCD_EN is defined.
module tb_contador_ocupacion;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ent = 1'b0;
    logic       sal = 1'b0;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       reject;
    logic       underflow;
    logic       alarm;
`ifdef CONTADOR_OCUPACION_BCD_EN
    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;
`endif

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    contador_ocupacion #(.CAPACITY(15), .CNT_W(4), .ALARM_CYC(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .ent       (ent),
        .sal       (sal),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .reject    (reject),
        .underflow (underflow),
`ifdef CONTADOR_OCUPACION_BCD_EN
        .bcd_tens  (bcd_tens),
        .bcd_units (bcd_units),
`endif
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    // One clock edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_ent();
        ent = 1'b1; step();
        ent = 1'b0; step();
    endtask

    task automatic pulse_sal();
        sal = 1'b1; step();
        sal = 1'b0; step();
    endtask

    initial begin
        // Reset state
        step(); step();
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_reject", 32'(reject), 0);
        check("rst_underflow", 32'(underflow), 0);
        check("rst_alarm", 32'(alarm), 0);
        rst = 1'b0; step();

        // 1: three single-cycle entries
        ent = 1'b1; step();
        check("ent1_count", 32'(count), 1);
        check("ent1_empty", 32'(empty), 0);
        ent = 1'b0; step();
        ent = 1'b1; step();
        check("ent2_count", 32'(count), 2);
        ent = 1'b0; step();
        ent = 1'b1; step();
        check("ent3_count", 32'(count), 3);
        ent = 1'b0; step();

        // 2: long level counts once
        ent = 1'b1; step();
        check("hold_first", 32'(count), 4);
        repeat (19) step();
        check("hold_end", 32'(count), 4);
        ent = 1'b0; step();

        // 3: underflow from empty
        repeat (4) pulse_sal();
        check("drain_count", 32'(count), 0);
        check("drain_empty", 32'(empty), 1);
        sal = 1'b1; step();
        check("uf_pulse", 32'(underflow), 1);
        check("uf_count", 32'(count), 0);
        sal = 1'b0; step();
        check("uf_one_cycle", 32'(underflow), 0);

        // 5a: simultaneous at 0
        ent = 1'b1; sal = 1'b1; step();
        check("both0_count", 32'(count), 0);
        check("both0_uf", 32'(underflow), 0);
        check("both0_rej", 32'(reject), 0);
        ent = 1'b0; sal = 1'b0; step();
        check("both0_uf_next", 32'(underflow), 0);

        // 4: fill to capacity, reject, alarm timing
        repeat (14) pulse_ent();
        check("fill14_full", 32'(full), 0);
        ent = 1'b1; step();
        check("fill15_count", 32'(count), 15);
        check("fill15_full", 32'(full), 1);
        check("fill15_alarm", 32'(alarm), 0);
        ent = 1'b0; step();
        step();
        ent = 1'b1; step();
        check("rej_pulse", 32'(reject), 1);
        check("rej_count", 32'(count), 15);
        check("rej_full", 32'(full), 1);
        ent = 1'b0; step();
        check("rej_one_cycle", 32'(reject), 0);
        step(); step(); step();
        check("alarm_7", 32'(alarm), 0);
        step();
        check("alarm_8", 32'(alarm), 1);

        // 5b: simultaneous at 15
        ent = 1'b1; sal = 1'b1; step();
        check("both15_count", 32'(count), 15);
        check("both15_rej", 32'(reject), 0);
        check("both15_alarm", 32'(alarm), 1);
        ent = 1'b0; sal = 1'b0; step();
        check("both15_rej_next", 32'(reject), 0);

        sal = 1'b1; step();
        check("exit_count", 32'(count), 14);
        check("exit_alarm", 32'(alarm), 0);
        check("exit_full", 32'(full), 0);
        sal = 1'b0; step();

        // 5c: simultaneous at 7
        repeat (7) pulse_sal();
        check("down7_count", 32'(count), 7);
        ent = 1'b1; sal = 1'b1; step();
        check("both7_count", 32'(count), 7);
        check("both7_rej", 32'(reject), 0);
        check("both7_uf", 32'(underflow), 0);
        ent = 1'b0; sal = 1'b0; step();

        repeat (5) pulse_ent();
        check("up12_count", 32'(count), 12);
`ifdef CONTADOR_OCUPACION_BCD_EN
        check("bcd12_tens", 32'(bcd_tens), 1);
        check("bcd12_units", 32'(bcd_units), 2);
`endif
        repeat (4) pulse_sal();
        check("down8_count", 32'(count), 8);

        // 6: asynchronous reset at count 9 with ent held
        ent = 1'b1; step();
        check("pre_rst_count", 32'(count), 9);
        rst = 1'b1; #1;
        check("arst_count", 32'(count), 0);
        check("arst_empty", 32'(empty), 1);
        check("arst_full", 32'(full), 0);
        check("arst_alarm", 32'(alarm), 0);
`ifdef CONTADOR_OCUPACION_BCD_EN
        check("arst_bcd_tens", 32'(bcd_tens), 0);
        check("arst_bcd_units", 32'(bcd_units), 0);
`endif
        step(); step();
        rst = 1'b0; step(); step(); step();
        check("held_after_rst", 32'(count), 0);
        check("held_empty", 32'(empty), 1);
        ent = 1'b0; step();
        ent = 1'b1; step();
        check("rearm_count", 32'(count), 1);
        ent = 1'b0; step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1, "timeout");
    end

endmodule
